// File: rtl/ps2_command_transmitter_pkg.sv
// Shared types and constants for the PS/2 host-to-device command path.
// State encodings, default link timing and the command bytes the game logic sends.
package ps2_command_transmitter_pkg;

    typedef enum logic [3:0] {
        TX_IDLE     = 4'd0,
        TX_INHIBIT  = 4'd1,
        TX_REQUEST  = 4'd2,
        TX_WAIT_CLK = 4'd3,
        TX_SHIFT    = 4'd4,
        TX_ACK      = 4'd5,
        TX_RELEASE  = 4'd6,
        TX_DONE     = 4'd7,
        TX_ERROR    = 4'd8
    } txState_t;

    localparam int CYCLE_COUNTER_WIDTH = 20;
    typedef logic [CYCLE_COUNTER_WIDTH-1:0] cycleCount_t;

    // Defaults assume a 50 MHz CLOCK_50.
    localparam int DEFAULT_CLK_HOLD_CYCLES   = 5000;
    localparam int DEFAULT_DATA_SETUP_CYCLES = 50;
    localparam int DEFAULT_START_TIMEOUT     = 750000;
    localparam int DEFAULT_XFER_TIMEOUT      = 100000;

    localparam logic [7:0] PS2CMD_SETLEDS = 8'hED;
    localparam logic [7:0] PS2CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2CMD_RESET   = 8'hFF;

    // PS/2 frames carry odd parity: data plus parity has an odd number of ones.
    function automatic logic oddParity(input logic [7:0] dataByte);
        return ~^dataByte;
    endfunction

endpackage

// File: rtl/ps2_command_transmitter_if.sv
// Command handshake between the game logic (master) and the PS/2 transmitter (slave).
interface ps2_command_transmitter_if;

    logic [7:0] commandToSend;
    logic       sendCommand;
    logic       busy;
    logic       commandWasSent;
    logic       errorCommunicationTimedOut;

    modport master (
        output commandToSend,
        output sendCommand,
        input  busy,
        input  commandWasSent,
        input  errorCommunicationTimedOut
    );

    modport slave (
        input  commandToSend,
        input  sendCommand,
        output busy,
        output commandWasSent,
        output errorCommunicationTimedOut
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data pins plus a clock falling-edge strobe.
// Shared with the scan-code receiver.
module ps2_line_sync (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic ps2ClkIn,
    input  logic ps2DatIn,
    output logic clkSync,
    output logic datSync,
    output logic clkFall
);

    logic clkMeta;
    logic datMeta;
    logic clkPrev;

    // Reset to the idle (released, pulled-up) line level so no false edge follows reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clkMeta <= 1'b1;
            clkSync <= 1'b1;
            clkPrev <= 1'b1;
            datMeta <= 1'b1;
            datSync <= 1'b1;
        end else begin
            clkMeta <= ps2ClkIn;
            clkSync <= clkMeta;
            clkPrev <= clkSync;
            datMeta <= ps2DatIn;
            datSync <= datMeta;
        end
    end

    assign clkFall = clkPrev & ~clkSync;

endmodule

// File: rtl/ps2_command_transmitter.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, 11-bit frame clocked by the
// device, ACK check, and one-cycle done/timeout pulses. Drive-low outputs feed open-drain pads.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// TX_IDLE     | lines released, waiting for sendCommand
// TX_INHIBIT  | PS2_CLK held low to stop the device
// TX_REQUEST  | PS2_CLK and PS2_DAT both low (start bit set up)
// TX_WAIT_CLK | clock released, start bit held, waiting for first device edge
// TX_SHIFT    | data bits, parity and stop presented on device falling edges
// TX_ACK      | waiting for the 11th falling edge to sample device ACK
// TX_RELEASE  | waiting for device to release both lines
// TX_DONE     | one-cycle success pulse
// TX_ERROR    | one-cycle timeout / missing-ACK pulse
module ps2_command_transmitter
    import ps2_command_transmitter_pkg::*;
#(
    parameter int CLK_HOLD_CYCLES   = DEFAULT_CLK_HOLD_CYCLES,
    parameter int DATA_SETUP_CYCLES = DEFAULT_DATA_SETUP_CYCLES,
    parameter int START_TIMEOUT     = DEFAULT_START_TIMEOUT,
    parameter int XFER_TIMEOUT      = DEFAULT_XFER_TIMEOUT
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic ps2ClkIn,
    input  logic ps2DatIn,
    output logic ps2ClkDriveLow,
    output logic ps2DatDriveLow,
    ps2_command_transmitter_if.slave cmdBus
);

    localparam cycleCount_t HOLD_LAST  = cycleCount_t'(CLK_HOLD_CYCLES - 1);
    localparam cycleCount_t SETUP_LAST = cycleCount_t'(DATA_SETUP_CYCLES - 1);
    localparam cycleCount_t START_LAST = cycleCount_t'(START_TIMEOUT - 1);
    localparam cycleCount_t XFER_LAST  = cycleCount_t'(XFER_TIMEOUT - 1);

    logic clkSync;
    logic datSync;
    logic clkFall;

    ps2_line_sync lineSync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .ps2ClkIn (ps2ClkIn),
        .ps2DatIn (ps2DatIn),
        .clkSync  (clkSync),
        .datSync  (datSync),
        .clkFall  (clkFall)
    );

    txState_t    state;
    txState_t    stateNext;
    cycleCount_t cycleCounter;
    cycleCount_t cycleCounterNext;
    logic [3:0]  bitCount;
    logic [3:0]  bitCountNext;
    logic [7:0]  txByte;
    logic [7:0]  txByteNext;
    logic        txParity;
    logic        txParityNext;
    logic        shiftDat;
    logic        clkDriveNext;
    logic        datDriveNext;
    logic        busyReg;
    logic        sentReg;
    logic        errorReg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= TX_IDLE;
            cycleCounter   <= '0;
            bitCount       <= '0;
            txByte         <= '0;
            txParity       <= 1'b0;
            ps2ClkDriveLow <= 1'b0;
            ps2DatDriveLow <= 1'b0;
            busyReg        <= 1'b0;
            sentReg        <= 1'b0;
            errorReg       <= 1'b0;
        end else begin
            state          <= stateNext;
            cycleCounter   <= cycleCounterNext;
            bitCount       <= bitCountNext;
            txByte         <= txByteNext;
            txParity       <= txParityNext;
            ps2ClkDriveLow <= clkDriveNext;
            ps2DatDriveLow <= datDriveNext;
            busyReg        <= (stateNext != TX_IDLE);
            sentReg        <= (stateNext == TX_DONE);
            errorReg       <= (stateNext == TX_ERROR);
        end
    end

    always_comb begin
        stateNext    = state;
        bitCountNext = bitCount;
        txByteNext   = txByte;
        txParityNext = txParity;
        shiftDat     = ps2DatDriveLow;

        case (state)
            TX_IDLE: begin
                if (cmdBus.sendCommand) begin
                    stateNext    = TX_INHIBIT;
                    txByteNext   = cmdBus.commandToSend;
                    txParityNext = oddParity(cmdBus.commandToSend);
                    bitCountNext = '0;
                end
            end
            TX_INHIBIT: begin
                if (cycleCounter == HOLD_LAST) begin
                    stateNext = TX_REQUEST;
                end
            end
            TX_REQUEST: begin
                if (cycleCounter == SETUP_LAST) begin
                    stateNext = TX_WAIT_CLK;
                end
            end
            TX_WAIT_CLK: begin
                if (cycleCounter == START_LAST) begin
                    stateNext = TX_ERROR;
                end else if (clkFall) begin
                    stateNext    = TX_SHIFT;
                    bitCountNext = 4'd1;
                    shiftDat     = ~txByte[0];
                end
            end
            TX_SHIFT: begin
                if (cycleCounter == XFER_LAST) begin
                    stateNext = TX_ERROR;
                end else if (clkFall) begin
                    // bitCount holds the number of edges seen so far; this edge is bitCount+1.
                    bitCountNext = bitCount + 4'd1;
                    if (bitCount < 4'd8) begin
                        shiftDat = ~txByte[bitCount[2:0]];
                    end else if (bitCount == 4'd8) begin
                        shiftDat = ~txParity;
                    end else begin
                        shiftDat  = 1'b0;
                        stateNext = TX_ACK;
                    end
                end
            end
            TX_ACK: begin
                if (cycleCounter == XFER_LAST) begin
                    stateNext = TX_ERROR;
                end else if (clkFall) begin
                    stateNext = datSync ? TX_ERROR : TX_RELEASE;
                end
            end
            TX_RELEASE: begin
                if (cycleCounter == XFER_LAST) begin
                    stateNext = TX_ERROR;
                end else if (clkSync && datSync) begin
                    stateNext = TX_DONE;
                end
            end
            TX_DONE:  stateNext = TX_IDLE;
            TX_ERROR: stateNext = TX_IDLE;
            default:  stateNext = TX_IDLE;
        endcase
    end

    // The transfer timeout spans SHIFT through RELEASE, so only those hand-offs keep the count.
    always_comb begin
        cycleCounterNext = (cycleCounter == '1) ? cycleCounter : cycleCounter + cycleCount_t'(1);
        if ((stateNext != state) && (stateNext != TX_ACK) && (stateNext != TX_RELEASE)) begin
            cycleCounterNext = '0;
        end
    end

    always_comb begin
        clkDriveNext = (stateNext == TX_INHIBIT) || (stateNext == TX_REQUEST);
        case (stateNext)
            TX_REQUEST:  datDriveNext = 1'b1;
            TX_WAIT_CLK: datDriveNext = 1'b1;
            TX_SHIFT:    datDriveNext = shiftDat;
            default:     datDriveNext = 1'b0;
        endcase
    end

    assign cmdBus.busy                       = busyReg;
    assign cmdBus.commandWasSent             = sentReg;
    assign cmdBus.errorCommunicationTimedOut = errorReg;

endmodule

// File: tb/tb_ps2_command_transmitter.sv
// Scoreboard bench for ps2_command_transmitter with an open-drain PS/2 device model.
module tb_ps2_command_transmitter;
    import ps2_command_transmitter_pkg::*;

    localparam int HOLD_CYC  = 20;
    localparam int SETUP_CYC = 4;
    localparam int START_TO  = 200;
    localparam int XFER_TO   = 2000;

    logic CLOCK_50;
    logic reset;
    logic devClk;
    logic devDat;
    logic ps2ClkIn;
    logic ps2DatIn;
    logic ps2ClkDriveLow;
    logic ps2DatDriveLow;

    ps2_command_transmitter_if cmdIf ();

    ps2_command_transmitter #(
        .CLK_HOLD_CYCLES   (HOLD_CYC),
        .DATA_SETUP_CYCLES (SETUP_CYC),
        .START_TIMEOUT     (START_TO),
        .XFER_TIMEOUT      (XFER_TO)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .ps2ClkIn       (ps2ClkIn),
        .ps2DatIn       (ps2DatIn),
        .ps2ClkDriveLow (ps2ClkDriveLow),
        .ps2DatDriveLow (ps2DatDriveLow),
        .cmdBus         (cmdIf)
    );

    // Wired-AND of the open-drain host and device drivers.
    assign ps2ClkIn = devClk & ~ps2ClkDriveLow;
    assign ps2DatIn = devDat & ~ps2DatDriveLow;

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int cycleCount = 0;
    always @(posedge CLOCK_50) cycleCount <= cycleCount + 1;

    typedef struct {
        bit         expectSent;
        bit         checkFrame;
        bit         checkTimeout;
        logic [10:0] frame;
    } expect_t;

    expect_t     expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          releaseCycle = 0;
    logic [10:0] capturedFrame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cycleCount);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit doPush, input bit expSent,
                            input bit chkFrame, input bit parity, input bit chkTimeout);
        expect_t e;
        @(negedge CLOCK_50);
        check("idleBeforeSend", 32'(cmdIf.busy), 32'd0);
        cmdIf.commandToSend = b;
        cmdIf.sendCommand   = 1'b1;
        if (doPush) begin
            e.expectSent   = expSent;
            e.checkFrame   = chkFrame;
            e.checkTimeout = chkTimeout;
            e.frame        = {1'b1, parity, b, 1'b0};
            expQ.push_back(e);
        end
        @(negedge CLOCK_50);
        cmdIf.sendCommand = 1'b0;
        check("busyRise", 32'(cmdIf.busy), 32'd1);
    endtask

    // Device side: measures inhibit/setup, then produces numFalls clock pulses (40-cycle period).
    task automatic runDevice(input int numFalls, input bit doAck);
        int n;
        capturedFrame = '0;
        n = 0;
        while (!ps2ClkDriveLow && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("inhibitStart", 32'(ps2ClkDriveLow), 32'd1);
        n = 0;
        while (ps2ClkDriveLow && !ps2DatDriveLow && n < 200) begin
            n++;
            @(negedge CLOCK_50);
        end
        check("inhibitLen", 32'(n), 32'(HOLD_CYC));
        n = 0;
        while (ps2ClkDriveLow && ps2DatDriveLow && n < 200) begin
            n++;
            @(negedge CLOCK_50);
        end
        check("setupLen", 32'(n), 32'(SETUP_CYC));
        releaseCycle = cycleCount;
        check("startHeld", 32'(ps2DatIn), 32'd0);
        if (numFalls == 0) return;
        repeat (10) @(negedge CLOCK_50);
        capturedFrame[0] = ps2DatIn;
        for (int k = 1; k <= numFalls; k++) begin
            devClk = 1'b0;
            repeat (20) @(negedge CLOCK_50);
            devClk = 1'b1;
            if (k <= 10) capturedFrame[k] = ps2DatIn;
            if (k == 10 && doAck) devDat = 1'b0;
            if (k == 11) devDat = 1'b1;
            repeat (20) @(negedge CLOCK_50);
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while (cmdIf.busy && n < maxCycles) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("idleTimeout", 32'(cmdIf.busy), 32'd0);
        repeat (3) @(negedge CLOCK_50);
    endtask

    // Monitor: pops an expectation on every completion/error pulse.
    initial begin
        expect_t e;
        forever begin
            @(negedge CLOCK_50);
            if (cmdIf.commandWasSent || cmdIf.errorCommunicationTimedOut) begin
                check("pulseExclusive", 32'(cmdIf.commandWasSent && cmdIf.errorCommunicationTimedOut), 32'd0);
                check("drivesAtPulse", 32'({ps2ClkDriveLow, ps2DatDriveLow}), 32'd0);
                if (expQ.size() == 0) begin
                    check("unexpectedPulse", 32'({cmdIf.commandWasSent, cmdIf.errorCommunicationTimedOut}), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    check("outcomeSent", 32'(cmdIf.commandWasSent), 32'(e.expectSent));
                    check("outcomeError", 32'(cmdIf.errorCommunicationTimedOut), 32'(!e.expectSent));
                    if (e.checkFrame) check("frameBits", 32'(capturedFrame), 32'(e.frame));
                    if (e.checkTimeout) check("startTimeout", 32'(cycleCount - releaseCycle), 32'(START_TO));
                end
                @(negedge CLOCK_50);
                check("pulseWidth", 32'({cmdIf.commandWasSent, cmdIf.errorCommunicationTimedOut}), 32'd0);
                check("busyAfterPulse", 32'(cmdIf.busy), 32'd0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cycleCount);
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        devClk              = 1'b1;
        devDat              = 1'b1;
        cmdIf.sendCommand   = 1'b0;
        cmdIf.commandToSend = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        check("rstClkDrive", 32'(ps2ClkDriveLow), 32'd0);
        check("rstDatDrive", 32'(ps2DatDriveLow), 32'd0);
        check("rstBusy", 32'(cmdIf.busy), 32'd0);
        check("rstPulses", 32'({cmdIf.commandWasSent, cmdIf.errorCommunicationTimedOut}), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        // 0xED: data 1,0,1,1,0,1,1,1, parity 1, ACKed.
        sendByte(PS2CMD_SETLEDS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        runDevice(11, 1'b1);
        waitIdle(200);

        // 0xF4: data 0,0,1,0,1,1,1,1, parity 0.
        sendByte(PS2CMD_ENABLE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        runDevice(11, 1'b1);
        waitIdle(200);

        // Device never clocks: error exactly START_TO cycles after clock release.
        sendByte(PS2CMD_ENABLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        runDevice(0, 1'b0);
        waitIdle(400);

        // No ACK from device: data high at edge 11. 0x01 carries parity 0.
        sendByte(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        runDevice(11, 1'b0);
        waitIdle(200);

        // Reset while data bit 4 of 0xFF is on the line: no pulse expected.
        sendByte(PS2CMD_RESET, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runDevice(5, 1'b1);
        check("midXferBusy", 32'(cmdIf.busy), 32'd1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("resetClkDrive", 32'(ps2ClkDriveLow), 32'd0);
        check("resetDatDrive", 32'(ps2DatDriveLow), 32'd0);
        check("resetBusy", 32'(cmdIf.busy), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (30) @(negedge CLOCK_50);
        sendByte(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        runDevice(11, 1'b1);
        waitIdle(200);

        // 0x55 requested while busy is dropped; 0xED goes out unchanged.
        sendByte(PS2CMD_SETLEDS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        fork
            runDevice(11, 1'b1);
            begin
                repeat (8) @(negedge CLOCK_50);
                cmdIf.commandToSend = 8'h55;
                cmdIf.sendCommand   = 1'b1;
                @(negedge CLOCK_50);
                cmdIf.sendCommand   = 1'b0;
            end
        join
        waitIdle(200);
        repeat (60) @(negedge CLOCK_50);
        check("busyStaysLow", 32'(cmdIf.busy), 32'd0);
        check("queueDrained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
